ccff_bitstream_loader: RTL and testbench

//  - Drives the configuration-chain (ccff) protocol from the loader side: takes bitstream words on a valid/ready

---
 rtl/ccff_bitstream_loader_pkg.sv | 11 +
 rtl/ccff_word_serializer.sv | 47 ++++
 rtl/ccff_bitstream_loader.sv | 154 +++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types for the ccff bitstream loader and its word serialiser.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// Parallel-load shift register with a wrapping in-word bit counter. Serialises
// bitstream words MSB-first, or packs a serial stream when fed through serial_i.
module ccff_word_serializer #(
    parameter int WORD_W = 32,
    parameter int WB_W   = $clog2(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              shift_i,
    input  logic              serial_i,
    output logic [WORD_W-1:0] shreg_o,
    output logic              msb_d_o,
    output logic [WB_W-1:0]   cnt_o
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WB_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WORD_W-2:0], serial_i};
            cnt_d   = (cnt_q == WB_W'(WORD_W-1)) ? '0 : cnt_q + WB_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shreg_o = shreg_q;
    assign msb_d_o = shreg_d[WORD_W-1];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads CHAIN_LEN bits per start from a valid/ready word stream into the ccff chain head.
// Define CCFF_READBACK_EN to also pack ccff_tail into rb_data words.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 4096,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int CNT_W = $clog2(CHAIN_LEN+1);
    localparam int WB_W  = $clog2(WORD_W);

    ccff_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             aborted_q, aborted_d;
    logic             abort_hit, ld_word, word_last, chain_last, ser_msb_d;
    logic [WB_W-1:0]  ser_cnt;
    logic [WORD_W-1:0] unused_ser_shreg;

    assign abort_hit  = abort && (state_q == FETCH || state_q == SHIFT);
    // abort wins over a same-cycle handshake: the word is dropped
    assign ld_word    = (state_q == FETCH) && s_valid && !abort;
    assign word_last  = ser_cnt == WB_W'(WORD_W-1);
    assign chain_last = bit_cnt_q == CNT_W'(CHAIN_LEN-1);

    ccff_word_serializer #(.WORD_W(WORD_W), .WB_W(WB_W)) u_ser (
        .clk_i    (prog_clk),
        .rst_i    (prog_reset),
        .load_i   (ld_word),
        .data_i   (s_data),
        .shift_i  (state_q == SHIFT),
        .serial_i (1'b0),
        .shreg_o  (unused_ser_shreg),
        .msb_d_o  (ser_msb_d),
        .cnt_o    (ser_cnt)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (abort) state_d = IDLE;
                     else if (s_valid) state_d = SHIFT;
            SHIFT:   if (abort) state_d = IDLE;
                     else if (chain_last) state_d = DONE;
                     else if (word_last) state_d = FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // head/shift_en are registered from the next state so they line up with SHIFT cycles
    always_comb begin
        s_ready    = state_q == FETCH;
        busy       = state_q == FETCH || state_q == SHIFT;
        done       = state_q == DONE;
        shift_en_d = state_d == SHIFT;
        head_d     = shift_en_d & ser_msb_d;
        aborted_d  = abort_hit;
        bit_cnt_d  = bit_cnt_q;
        if (state_q == IDLE && start) bit_cnt_d = '0;
        else if (state_q == SHIFT)    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bit_cnt_q  <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            aborted_q  <= aborted_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign aborted       = aborted_q;

`ifdef CCFF_READBACK_EN
    logic              rb_clr, rb_evt, rb_valid_q, unused_rb_msb, unused_rb_top;
    logic [WORD_W-1:0] rb_shreg, rb_word, rb_data_q, rb_data_d;
    logic [WB_W-1:0]   rb_cnt;

    assign rb_clr = (state_q == IDLE && start) || abort_hit;
    // tail is sampled on the same edge the chain shifts, i.e. every SHIFT cycle
    assign rb_evt = shift_en_q && (rb_cnt == WB_W'(WORD_W-1) || chain_last);
    assign rb_word = {rb_shreg[WORD_W-2:0], ccff_tail};
    assign unused_rb_top = rb_shreg[WORD_W-1];

    ccff_word_serializer #(.WORD_W(WORD_W), .WB_W(WB_W)) u_rb (
        .clk_i    (prog_clk),
        .rst_i    (prog_reset),
        .load_i   (rb_clr),
        .data_i   ('0),
        .shift_i  (shift_en_q),
        .serial_i (ccff_tail),
        .shreg_o  (rb_shreg),
        .msb_d_o  (unused_rb_msb),
        .cnt_o    (rb_cnt)
    );

    // partial final word is left-justified; the shift also discards stale upper bits
    always_comb begin
        rb_data_d = rb_data_q;
        if (rb_evt) rb_data_d = rb_word << (WB_W'(WORD_W-1) - rb_cnt);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_evt;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader with a behavioural 40-flop chain model.
module tb_ccff_bitstream_loader;
    localparam int CL = 40;
    localparam int WW = 16;

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, aborted, rb_valid;
    logic [WW-1:0] rb_data;

    logic [CL-1:0] chain = '0;
    int n_shift = 0, n_done = 0, n_hs = 0, n_busy = 0, n_abt = 0, n_rb = 0;
    logic [WW-1:0] rbq[$];
    int total = 0, bad = 0;

    typedef struct {
        logic [3*WW-1:0] words;
        int              g1, g2, g3;
        logic [CL-1:0]   exp_chain;
    } vec_t;
    vec_t vecs[4];

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .aborted(aborted), .rb_data(rb_data), .rb_valid(rb_valid)
    );

    always #5 prog_clk = ~prog_clk;

    // chain model: first bit shifted ends up in the MSB of 'chain'; tail is the last flop
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain   <= {chain[CL-2:0], ccff_head};
            n_shift <= n_shift + 1;
        end
        if (done)              n_done <= n_done + 1;
        if (s_valid && s_ready) n_hs  <= n_hs + 1;
        if (busy)              n_busy <= n_busy + 1;
        if (aborted)           n_abt  <= n_abt + 1;
        if (rb_valid) begin
            n_rb <= n_rb + 1;
            rbq.push_back(rb_data);
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bits of the word stream, MSB first, truncated to the chain length
    function automatic logic [CL-1:0] model_chain(input logic [3*WW-1:0] w);
        logic [CL-1:0] c;
        int n;
        c = '0;
        n = 0;
        for (int k = 0; k < 3; k++)
            for (int b = WW-1; b >= 0; b--)
                if (n < CL) begin
                    c = {c[CL-2:0], w[(2-k)*WW + b]};
                    n++;
                end
        return c;
    endfunction

    task automatic feed_word(input logic [WW-1:0] w, input int gap);
        int t;
        t = 0;
        s_data  = w;
        s_valid = (gap == 0);
        while (!s_ready && t < 64) begin
            tick();
            t++;
        end
        chk("ready_seen", s_ready, 1);
        s_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("gap_shift_en", ccff_shift_en, 0);
        end
        s_valid = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        chk("load_timeout_busy", busy, 0);
        chk("done_pulse", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic do_load(input string name, input logic [3*WW-1:0] w,
                           input int g1, input int g2, input int g3, input logic [CL-1:0] exp);
        int s0, d0, h0, b0, a0;
        s0 = n_shift; d0 = n_done; h0 = n_hs; b0 = n_busy; a0 = n_abt;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_word(w[47:32], g1);
        feed_word(w[31:16], g2);
        feed_word(w[15:0],  g3);
        s_valid = 1'b0;
        wait_idle();
        chk({name, "_chain"}, chain, exp);
        chk({name, "_shifts"}, n_shift - s0, CL);
        chk({name, "_dones"}, n_done - d0, 1);
        chk({name, "_handshakes"}, n_hs - h0, (CL + WW - 1) / WW);
        chk({name, "_busy_cycles"}, n_busy - b0, CL + (CL + WW - 1) / WW + g1 + g2 + g3);
        chk({name, "_no_abort"}, n_abt - a0, 0);
    endtask

    initial begin
        int s0, d0, a0, r0;
        logic [3*WW-1:0] w;
        int g1, g2, g3;
        logic [WW-1:0] rb_exp[3];

        vecs[0] = '{48'hA5C3_1234_FF00, 0, 0, 0, 40'hA5_C312_34FF};
        vecs[1] = '{48'hA5C3_1234_FF00, 0, 5, 0, 40'hA5_C312_34FF};
        vecs[2] = '{48'hFFFF_0000_FFFF, 1, 2, 3, 40'hFF_FF00_00FF};
        vecs[3] = '{48'h0001_8000_00FF, 0, 0, 4, 40'h00_0180_0000};

        repeat (3) tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_shift_en", ccff_shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_rb_valid", rb_valid, 0);
        chk("rst_rb_data", rb_data, 0);
        prog_reset = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", aborted, 0);

        for (int i = 0; i < 4; i++)
            do_load($sformatf("vec%0d", i), vecs[i].words, vecs[i].g1, vecs[i].g2, vecs[i].g3,
                    vecs[i].exp_chain);

        // abort on the 7th bit of word 2
        s0 = n_shift; d0 = n_done; a0 = n_abt;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_word(16'hA5C3, 0);
        feed_word(16'h1234, 0);
        repeat (6) tick();
        chk("abort_pre_shift_en", ccff_shift_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_shift_en", ccff_shift_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        tick();
        chk("abort_pulse_width", aborted, 0);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_shifts", n_shift - s0, 23);
        chk("abort_chain_tail", chain[22:0], {16'hA5C3, 7'b0001001});
        chk("abort_count", n_abt - a0, 1);
        do_load("reload", 48'hA5C3_1234_FF00, 0, 0, 0, 40'hA5_C312_34FF);

        // synchronous reset in the middle of word 1
        d0 = n_done; a0 = n_abt;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_word(16'h5A5A, 0);
        repeat (3) tick();
        prog_reset = 1'b1;
        tick();
        chk("midrst_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, aborted, rb_valid}, 0);
        prog_reset = 1'b0;
        s_valid = 1'b0;
        repeat (2) tick();
        chk("midrst_idle", busy, 0);
        chk("midrst_no_done", n_done - d0, 0);
        chk("midrst_no_abort", n_abt - a0, 0);

        // start while busy must not restart the load
        s0 = n_shift; d0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_word(16'hA5C3, 0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy_keeps_busy", busy, 1);
        feed_word(16'h1234, 0);
        feed_word(16'hFF00, 0);
        s_valid = 1'b0;
        wait_idle();
        chk("start_busy_chain", chain, 40'hA5_C312_34FF);
        chk("start_busy_shifts", n_shift - s0, CL);
        chk("start_busy_dones", n_done - d0, 1);

        for (int i = 0; i < 6; i++) begin
            w  = {$urandom(), $urandom()};
            g1 = $urandom_range(0, 3);
            g2 = $urandom_range(0, 3);
            g3 = $urandom_range(0, 3);
            do_load($sformatf("rand%0d", i), w, g1, g2, g3, model_chain(w));
        end

`ifdef CCFF_READBACK_EN
        do_load("rb_pre", 48'hDEAD_BEEF_7700, 0, 0, 0, 40'hDE_ADBE_EF77);
        r0 = rbq.size();
        rb_exp[0] = 16'hDEAD;
        rb_exp[1] = 16'hBEEF;
        rb_exp[2] = 16'h7700;
        do_load("rb_run", 48'h0123_4567_89AB, 0, 0, 0, 40'h01_2345_6789);
        chk("rb_count", rbq.size() - r0, 3);
        for (int i = 0; i < 3; i++)
            if (rbq.size() > r0 + i) chk($sformatf("rb_word%0d", i), rbq[r0 + i], rb_exp[i]);
`else
        r0 = n_rb;
        chk("rb_never_valid", r0, 0);
        chk("rb_data_zero", rb_data, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
